// File: rtl/maze_fsm_ml.sv
// -----------------------------------------------------------------------------
// maze_fsm_ml - top-level game controller for the VGA maze game.
//
// Sequences each game tick: erase the player, latch the key, look up the
// obstacle memory for the target cell, step the position, redraw, and check
// for a win. Adds multi-level play, a lives counter, an internally counted
// freeze on ice, and a pause input.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   timer_done_i             move-tick pulse from the timer datapath
//   move_i[2:0]              0 none, 1 left, 2 right, 3 up, 4 down
//   obs_wall_i/lava_i/ice_i  obstacle flags for the target cell
//   win_i                    player is on the end cell
//   pause_i                  hold the game in WAIT_TIMER
//   en_xpos_o/s_xpos_o       x position: 0 start, 1 inc, 2 dec, 3 end
//   en_ypos_o/s_ypos_o       y position: 0 start, 1 inc, 2 dec, 3 end
//   en_key_o/s_key_o         key register: 0 clear, 1 latch
//   en_obs_o/s_obs_o         obstacle-memory address select
//   en_timer_o/s_timer_o     move timer: 0 clear, 1 count
//   en_clockt_o/s_clockt_o   game clock enable / 0 clear
//   plot_o, s_color_o        VGA plot strobe, colour 0 blk 1 plr 2 ice 3 end
//   level_o                  current level (maze memory bank)
//   lives_left_o             remaining lives
//   game_over_o              high in GAME_OVER
//   state_cur_o              current state code
// -----------------------------------------------------------------------------
module maze_fsm_ml #(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned LEVELS       = 4,
  parameter int unsigned FREEZE_TICKS = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       timer_done_i,
  input  logic [2:0] move_i,
  input  logic       obs_wall_i,
  input  logic       obs_lava_i,
  input  logic       obs_ice_i,
  input  logic       win_i,
  input  logic       pause_i,
  output logic       en_xpos_o,
  output logic [1:0] s_xpos_o,
  output logic       en_ypos_o,
  output logic [1:0] s_ypos_o,
  output logic       en_key_o,
  output logic       s_key_o,
  output logic       en_obs_o,
  output logic [2:0] s_obs_o,
  output logic       en_timer_o,
  output logic       s_timer_o,
  output logic       en_clockt_o,
  output logic       s_clockt_o,
  output logic       plot_o,
  output logic [1:0] s_color_o,
  output logic [3:0] level_o,
  output logic [3:0] lives_left_o,
  output logic       game_over_o,
  output logic [4:0] state_cur_o
);

  typedef enum logic [4:0] {
    S_INIT         = 5'd0,
    S_WAIT_TIMER   = 5'd1,
    S_ERASE        = 5'd2,
    S_READ_KEY     = 5'd3,
    S_UPDATE_OBS   = 5'd4,
    S_WAIT_OBS     = 5'd5,
    S_TEST_OBS     = 5'd6,
    S_RESTART      = 5'd7,
    S_FROZEN       = 5'd8,
    S_LEVEL_UP     = 5'd9,
    S_GAME_OVER    = 5'd10,
    S_INC_XPOS     = 5'd15,
    S_DEC_XPOS     = 5'd16,
    S_INC_YPOS     = 5'd17,
    S_DEC_YPOS     = 5'd18,
    S_DRAW         = 5'd20,
    S_WIN          = 5'd21,
    S_INIT_RESET   = 5'd22,
    S_INIT_SET_END = 5'd23
  } state_e;

  localparam logic [3:0] LIVES_INIT = 4'(LIVES);
  localparam logic [3:0] LAST_LEVEL = 4'(LEVELS - 1);
  localparam logic [7:0] FREEZE_END = 8'(FREEZE_TICKS - 1);

  state_e     state_q, state_d;
  logic [3:0] level_q, level_d;
  logic [3:0] lives_q, lives_d;
  logic [7:0] freeze_q, freeze_d;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    lives_d  = lives_q;
    freeze_d = freeze_q;
    case (state_q)
      S_INIT_RESET:   state_d = S_INIT_SET_END;
      S_INIT_SET_END: state_d = S_INIT;
      S_INIT:         state_d = S_WAIT_TIMER;
      S_WAIT_TIMER: begin
        if (timer_done_i && !pause_i) state_d = S_ERASE;
      end
      S_ERASE:        state_d = S_READ_KEY;
      S_READ_KEY:     state_d = S_UPDATE_OBS;
      S_UPDATE_OBS:   state_d = S_WAIT_OBS;
      S_WAIT_OBS:     state_d = S_TEST_OBS;
      S_TEST_OBS: begin
        if (obs_wall_i) begin
          state_d = S_DRAW;
        end else if (obs_lava_i) begin
          // Saturating decrement; the last life goes straight to GAME_OVER.
          if (lives_q != 4'd0) lives_d = lives_q - 4'd1;
          state_d = (lives_q <= 4'd1) ? S_GAME_OVER : S_RESTART;
        end else if (obs_ice_i) begin
          freeze_d = 8'd0;
          state_d  = S_FROZEN;
        end else begin
          case (move_i)
            3'd1:    state_d = S_DEC_XPOS;
            3'd2:    state_d = S_INC_XPOS;
            3'd3:    state_d = S_DEC_YPOS;
            3'd4:    state_d = S_INC_YPOS;
            default: state_d = S_DRAW;
          endcase
        end
      end
      S_RESTART:      state_d = S_DRAW;
      S_FROZEN: begin
        // Only move-tick pulses count toward the freeze duration.
        if (timer_done_i) begin
          if (freeze_q == FREEZE_END) begin
            freeze_d = 8'd0;
            state_d  = S_WAIT_TIMER;
          end else begin
            freeze_d = freeze_q + 8'd1;
          end
        end
      end
      S_INC_XPOS, S_DEC_XPOS, S_INC_YPOS, S_DEC_YPOS: state_d = S_DRAW;
      S_DRAW: begin
        if (win_i) state_d = (level_q == LAST_LEVEL) ? S_WIN : S_LEVEL_UP;
        else       state_d = S_WAIT_TIMER;
      end
      S_LEVEL_UP: begin
        level_d = level_q + 4'd1;
        state_d = S_INIT_RESET;
      end
      S_WIN:          state_d = S_WIN;
      S_GAME_OVER: begin
        lives_d = 4'd0;
        state_d = S_GAME_OVER;
      end
      default:        state_d = S_INIT_RESET;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_INIT_RESET;
      level_q  <= 4'd0;
      lives_q  <= LIVES_INIT;
      freeze_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      lives_q  <= lives_d;
      freeze_q <= freeze_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode (Moore, plus pause gating of the timer in WAIT_TIMER)
  // ---------------------------------------------------------------------------
  always_comb begin
    en_xpos_o   = 1'b0;
    s_xpos_o    = 2'd0;
    en_ypos_o   = 1'b0;
    s_ypos_o    = 2'd0;
    en_key_o    = 1'b0;
    s_key_o     = 1'b0;
    en_obs_o    = 1'b0;
    s_obs_o     = 3'd0;
    en_timer_o  = 1'b0;
    s_timer_o   = 1'b0;
    en_clockt_o = 1'b1;
    s_clockt_o  = 1'b1;
    plot_o      = 1'b0;
    s_color_o   = 2'd0;
    game_over_o = 1'b0;
    case (state_q)
      S_INIT_RESET: begin
        plot_o    = 1'b1;
        en_xpos_o = 1'b1;
        s_xpos_o  = 2'd3;
        en_ypos_o = 1'b1;
        s_ypos_o  = 2'd3;
      end
      S_INIT_SET_END: begin
        plot_o    = 1'b1;
        s_color_o = 2'd3;
      end
      S_INIT: begin
        en_timer_o = 1'b1;
        en_key_o   = 1'b1;
        en_obs_o   = 1'b1;
        en_xpos_o  = 1'b1;
        en_ypos_o  = 1'b1;
        // The game clock is cleared only at a fresh game, not between levels.
        s_clockt_o = !((level_q == 4'd0) && (lives_q == LIVES_INIT));
      end
      S_WAIT_TIMER: begin
        en_timer_o = !pause_i;
        s_timer_o  = 1'b1;
      end
      S_ERASE: begin
        plot_o     = 1'b1;
        en_timer_o = 1'b1;
      end
      S_READ_KEY: begin
        en_key_o = 1'b1;
        s_key_o  = 1'b1;
      end
      S_UPDATE_OBS: begin
        en_obs_o = 1'b1;
        s_obs_o  = move_i;
      end
      S_RESTART: begin
        en_xpos_o = 1'b1;
        en_ypos_o = 1'b1;
      end
      S_FROZEN: begin
        plot_o     = 1'b1;
        s_color_o  = 2'd2;
        en_timer_o = 1'b1;
        s_timer_o  = 1'b1;
      end
      S_INC_XPOS: begin
        en_xpos_o = 1'b1;
        s_xpos_o  = 2'd1;
      end
      S_DEC_XPOS: begin
        en_xpos_o = 1'b1;
        s_xpos_o  = 2'd2;
      end
      S_INC_YPOS: begin
        en_ypos_o = 1'b1;
        s_ypos_o  = 2'd1;
      end
      S_DEC_YPOS: begin
        en_ypos_o = 1'b1;
        s_ypos_o  = 2'd2;
      end
      S_DRAW: begin
        plot_o    = 1'b1;
        s_color_o = 2'd1;
      end
      S_WIN: begin
        en_clockt_o = 1'b0;
        plot_o      = 1'b1;
      end
      S_GAME_OVER: begin
        en_clockt_o = 1'b0;
        game_over_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign level_o      = level_q;
  assign lives_left_o = lives_q;
  assign state_cur_o  = state_q;

endmodule

// File: tb/tb_maze_fsm_ml.sv
// Directed bench for maze_fsm_ml (LIVES=3, LEVELS=4, FREEZE_TICKS=8).
module tb_maze_fsm_ml;

  logic       clk;
  logic       rst_n;
  logic       timer_done;
  logic [2:0] move;
  logic       obs_wall, obs_lava, obs_ice, win, pause;
  logic       en_xpos, en_ypos, en_key, s_key, en_obs, en_timer, s_timer;
  logic       en_clockt, s_clockt, plot, game_over;
  logic [1:0] s_xpos, s_ypos, s_color;
  logic [2:0] s_obs;
  logic [3:0] level, lives_left;
  logic [4:0] state_cur;

  int checks   = 0;
  int failures = 0;

  maze_fsm_ml #(.LIVES(3), .LEVELS(4), .FREEZE_TICKS(8)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .timer_done_i (timer_done),
    .move_i       (move),
    .obs_wall_i   (obs_wall),
    .obs_lava_i   (obs_lava),
    .obs_ice_i    (obs_ice),
    .win_i        (win),
    .pause_i      (pause),
    .en_xpos_o    (en_xpos),
    .s_xpos_o     (s_xpos),
    .en_ypos_o    (en_ypos),
    .s_ypos_o     (s_ypos),
    .en_key_o     (en_key),
    .s_key_o      (s_key),
    .en_obs_o     (en_obs),
    .s_obs_o      (s_obs),
    .en_timer_o   (en_timer),
    .s_timer_o    (s_timer),
    .en_clockt_o  (en_clockt),
    .s_clockt_o   (s_clockt),
    .plot_o       (plot),
    .s_color_o    (s_color),
    .level_o      (level),
    .lives_left_o (lives_left),
    .game_over_o  (game_over),
    .state_cur_o  (state_cur)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int td, mv, wall, lava, ice, wn, ps;  // inputs
    int st, pl, col, et, ex, sx;          // expected outputs after the edge
  } vec_t;

  vec_t vecs[33];

  function automatic vec_t mk(int td, int mv, int wall, int lava, int ice, int wn, int ps,
                              int st, int pl, int col, int et, int ex, int sx);
    vec_t v;
    v.td = td; v.mv = mv; v.wall = wall; v.lava = lava; v.ice = ice; v.wn = wn; v.ps = ps;
    v.st = st; v.pl = pl; v.col = col; v.et = et; v.ex = ex; v.sx = sx;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    timer_done = 1'b0; move = 3'd0; obs_wall = 1'b0; obs_lava = 1'b0;
    obs_ice = 1'b0; win = 1'b0; pause = 1'b0;
  endtask

  // From WAIT_TIMER: timer pulse, then walk to TEST_OBS with the given move.
  task automatic go_to_test_obs(input int mv, input string tag);
    move = 3'(mv);
    timer_done = 1'b1;
    step();
    timer_done = 1'b0;
    chk({tag, "_erase"}, int'(state_cur), 2);
    step();
    step();
    chk({tag, "_upd_obs"}, int'(state_cur), 4);
    chk({tag, "_s_obs"}, int'(s_obs), mv);
    step();
    step();
    chk({tag, "_test_obs"}, int'(state_cur), 6);
    $display("txn %s: reached TEST_OBS move=%0d", tag, mv);
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;

    // ---------------- reset state ----------------
    step();
    chk("rst_state", int'(state_cur), 22);
    chk("rst_s_xpos", int'(s_xpos), 3);
    chk("rst_s_ypos", int'(s_ypos), 3);
    chk("rst_en_xpos", int'(en_xpos), 1);
    chk("rst_plot", int'(plot), 1);
    chk("rst_level", int'(level), 0);
    chk("rst_lives", int'(lives_left), 3);
    $display("txn reset: state=%0d level=%0d lives=%0d", state_cur, level, lives_left);
    rst_n = 1'b1;
    step();
    chk("init_set_end", int'(state_cur), 23);
    chk("init_set_end_col", int'(s_color), 3);
    step();
    chk("init_state", int'(state_cur), 0);
    chk("init_s_clockt", int'(s_clockt), 0);
    chk("init_en_timer", int'(en_timer), 1);
    chk("init_s_timer", int'(s_timer), 0);
    step();
    chk("wait_state", int'(state_cur), 1);

    // ---------------- table: move, pause, wall, ice entry ----------------
    //            td mv w  l  i  wn p   st pl col et ex sx
    vecs[0]  = mk(1, 2, 0, 0, 0, 0, 0,  2, 1, 0, 1, 0, 0);
    vecs[1]  = mk(0, 2, 0, 0, 0, 0, 0,  3, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 2, 0, 0, 0, 0, 0,  4, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 2, 0, 0, 0, 0, 0,  5, 0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 2, 0, 0, 0, 0, 0,  6, 0, 0, 0, 0, 0);
    vecs[5]  = mk(0, 2, 0, 0, 0, 0, 0, 15, 0, 0, 0, 1, 1);
    vecs[6]  = mk(0, 2, 0, 0, 0, 0, 0, 20, 1, 1, 0, 0, 0);
    vecs[7]  = mk(0, 2, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0);
    vecs[8]  = mk(1, 2, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
    vecs[9]  = mk(0, 2, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
    vecs[10] = mk(1, 2, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
    vecs[11] = mk(0, 2, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0);
    vecs[12] = mk(1, 3, 0, 0, 0, 0, 0,  2, 1, 0, 1, 0, 0);
    vecs[13] = mk(0, 3, 0, 0, 0, 0, 0,  3, 0, 0, 0, 0, 0);
    vecs[14] = mk(0, 3, 0, 0, 0, 0, 0,  4, 0, 0, 0, 0, 0);
    vecs[15] = mk(0, 3, 0, 0, 0, 0, 0,  5, 0, 0, 0, 0, 0);
    vecs[16] = mk(0, 3, 0, 0, 0, 0, 0,  6, 0, 0, 0, 0, 0);
    vecs[17] = mk(0, 3, 0, 0, 0, 0, 0, 18, 0, 0, 0, 0, 0);
    vecs[18] = mk(0, 3, 0, 0, 0, 0, 0, 20, 1, 1, 0, 0, 0);
    vecs[19] = mk(0, 3, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0);
    vecs[20] = mk(1, 2, 0, 0, 0, 0, 0,  2, 1, 0, 1, 0, 0);
    vecs[21] = mk(0, 2, 0, 0, 0, 0, 0,  3, 0, 0, 0, 0, 0);
    vecs[22] = mk(0, 2, 0, 0, 0, 0, 0,  4, 0, 0, 0, 0, 0);
    vecs[23] = mk(0, 2, 0, 0, 0, 0, 0,  5, 0, 0, 0, 0, 0);
    vecs[24] = mk(0, 2, 0, 0, 0, 0, 0,  6, 0, 0, 0, 0, 0);
    vecs[25] = mk(0, 2, 1, 1, 1, 0, 0, 20, 1, 1, 0, 0, 0);
    vecs[26] = mk(0, 2, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0);
    vecs[27] = mk(1, 2, 0, 0, 0, 0, 0,  2, 1, 0, 1, 0, 0);
    vecs[28] = mk(0, 2, 0, 0, 0, 0, 0,  3, 0, 0, 0, 0, 0);
    vecs[29] = mk(0, 2, 0, 0, 0, 0, 0,  4, 0, 0, 0, 0, 0);
    vecs[30] = mk(0, 2, 0, 0, 0, 0, 0,  5, 0, 0, 0, 0, 0);
    vecs[31] = mk(0, 2, 0, 0, 0, 0, 0,  6, 0, 0, 0, 0, 0);
    vecs[32] = mk(0, 2, 0, 0, 1, 0, 0,  8, 1, 2, 1, 0, 0);

    for (int k = 0; k < 33; k++) begin
      timer_done = 1'(vecs[k].td);
      move       = 3'(vecs[k].mv);
      obs_wall   = 1'(vecs[k].wall);
      obs_lava   = 1'(vecs[k].lava);
      obs_ice    = 1'(vecs[k].ice);
      win        = 1'(vecs[k].wn);
      pause      = 1'(vecs[k].ps);
      step();
      chk($sformatf("row%0d_state", k), int'(state_cur), vecs[k].st);
      chk($sformatf("row%0d_plot", k), int'(plot), vecs[k].pl);
      chk($sformatf("row%0d_color", k), int'(s_color), vecs[k].col);
      chk($sformatf("row%0d_en_timer", k), int'(en_timer), vecs[k].et);
      chk($sformatf("row%0d_en_xpos", k), int'(en_xpos), vecs[k].ex);
      chk($sformatf("row%0d_s_xpos", k), int'(s_xpos), vecs[k].sx);
      $display("txn row%0d: td=%0d mv=%0d w/l/i=%0d%0d%0d p=%0d -> state=%0d",
               k, vecs[k].td, vecs[k].mv, vecs[k].wall, vecs[k].lava, vecs[k].ice,
               vecs[k].ps, state_cur);
    end
    clear_inputs();

    // ---------------- frozen duration: 7 pulses hold, 8th exits ----------------
    for (int p = 1; p <= 8; p++) begin
      timer_done = 1'b1;
      step();
      timer_done = 1'b0;
      chk($sformatf("frozen_pulse%0d_state", p), int'(state_cur), (p == 8) ? 1 : 8);
      if (p < 8) begin
        chk($sformatf("frozen_pulse%0d_color", p), int'(s_color), 2);
        step();
        chk($sformatf("frozen_idle%0d_state", p), int'(state_cur), 8);
        chk($sformatf("frozen_idle%0d_plot", p), int'(plot), 1);
      end
      $display("txn frozen pulse %0d: state=%0d", p, state_cur);
    end

    // ---------------- level up from level 0 ----------------
    go_to_test_obs(0, "lvl0");
    step();
    chk("lvl0_draw", int'(state_cur), 20);
    win = 1'b1;
    step();
    win = 1'b0;
    chk("lvl0_level_up", int'(state_cur), 9);
    step();
    chk("lvl0_init_reset", int'(state_cur), 22);
    chk("lvl0_level", int'(level), 1);
    chk("lvl0_lives", int'(lives_left), 3);
    step();
    step();
    chk("lvl1_init", int'(state_cur), 0);
    chk("lvl1_s_clockt", int'(s_clockt), 1);
    step();
    chk("lvl1_wait", int'(state_cur), 1);
    $display("txn level up: level=%0d", level);

    // ---------------- three lava hits ----------------
    for (int h = 1; h <= 3; h++) begin
      go_to_test_obs(2, $sformatf("lava%0d", h));
      obs_lava = 1'b1;
      obs_ice  = (h == 1);  // lava outranks ice
      step();
      obs_lava = 1'b0;
      obs_ice  = 1'b0;
      chk($sformatf("lava%0d_lives", h), int'(lives_left), 3 - h);
      if (h < 3) begin
        chk($sformatf("lava%0d_restart", h), int'(state_cur), 7);
        chk($sformatf("lava%0d_en_xpos", h), int'(en_xpos), 1);
        chk($sformatf("lava%0d_s_xpos", h), int'(s_xpos), 0);
        step();
        chk($sformatf("lava%0d_draw", h), int'(state_cur), 20);
        step();
        chk($sformatf("lava%0d_wait", h), int'(state_cur), 1);
      end else begin
        chk("lava3_game_over_state", int'(state_cur), 10);
        chk("lava3_game_over", int'(game_over), 1);
        chk("lava3_en_clockt", int'(en_clockt), 0);
      end
      $display("txn lava hit %0d: state=%0d lives=%0d", h, state_cur, lives_left);
    end
    timer_done = 1'b1;
    step();
    step();
    timer_done = 1'b0;
    chk("game_over_hold", int'(state_cur), 10);
    chk("game_over_lives", int'(lives_left), 0);

    // ---------------- reset from GAME_OVER, then reset mid-FROZEN ----------------
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    chk("rst2_wait", int'(state_cur), 1);
    go_to_test_obs(1, "ice2");
    obs_ice = 1'b1;
    step();
    obs_ice = 1'b0;
    chk("ice2_frozen", int'(state_cur), 8);
    for (int p = 0; p < 3; p++) begin
      timer_done = 1'b1;
      step();
      timer_done = 1'b0;
      step();
    end
    chk("ice2_still_frozen", int'(state_cur), 8);
    rst_n = 1'b0;
    #1;
    chk("midrst_state", int'(state_cur), 22);
    chk("midrst_s_xpos", int'(s_xpos), 3);
    chk("midrst_s_ypos", int'(s_ypos), 3);
    chk("midrst_level", int'(level), 0);
    chk("midrst_lives", int'(lives_left), 3);
    step();
    chk("midrst_hold", int'(state_cur), 22);
    rst_n = 1'b1;
    step();
    chk("midrst_23", int'(state_cur), 23);
    step();
    chk("midrst_init", int'(state_cur), 0);
    chk("midrst_s_clockt", int'(s_clockt), 0);
    step();
    $display("txn mid-frozen reset: state=%0d level=%0d lives=%0d", state_cur, level, lives_left);

    // ---------------- climb to the last level and win ----------------
    for (int lv = 0; lv < 4; lv++) begin
      go_to_test_obs(0, $sformatf("climb%0d", lv));
      step();
      chk($sformatf("climb%0d_draw", lv), int'(state_cur), 20);
      win = 1'b1;
      step();
      win = 1'b0;
      if (lv < 3) begin
        chk($sformatf("climb%0d_level_up", lv), int'(state_cur), 9);
        step();
        chk($sformatf("climb%0d_level", lv), int'(level), lv + 1);
        step();
        step();
        step();
        chk($sformatf("climb%0d_wait", lv), int'(state_cur), 1);
      end else begin
        chk("win_state", int'(state_cur), 21);
        chk("win_en_clockt", int'(en_clockt), 0);
        chk("win_plot", int'(plot), 1);
        chk("win_color", int'(s_color), 0);
        timer_done = 1'b1;
        step();
        step();
        timer_done = 1'b0;
        chk("win_hold", int'(state_cur), 21);
      end
      $display("txn climb %0d: state=%0d level=%0d", lv, state_cur, level);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/maze_fsm_ml.md
Name: maze_fsm_ml

Overview:
- Next-generation top-level controller FSM for the VGA maze game.
- Sequences the game: erase, read key, obstacle lookup, move, draw, win.
- Adds over the previous generation: multi-level play, a lives counter, an internally counted freeze duration (no external unfrozen strobe) and a pause input.
- Drives the existing xpos/ypos/key/obs/timer/clockt datapath through enable/select pairs and the VGA plot/colour lines.

Parameters:
- LIVES, 3, lives at game start (1..15).
- LEVELS, 4, number of maze levels (1..16).
- FREEZE_TICKS, 8, timer_done pulses spent frozen after stepping on ice (1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- timer_done  in  1  move-tick pulse from timer datapath
- move  in  3  0 none, 1 left, 2 right, 3 up, 4 down
- obs_wall, obs_lava, obs_ice  in  1 each  obstacle flags for target cell
- win  in  1  player is on end cell
- pause  in  1  hold game in WAIT_TIMER
- en_xpos/s_xpos, en_ypos/s_ypos  out  1/2  0 load start, 1 inc, 2 dec, 3 load end
- en_key/s_key  out  1/1  0 clear, 1 latch key
- en_obs/s_obs  out  1/3  obstacle-memory address select (0 start, else move)
- en_timer/s_timer  out  1/1  0 clear, 1 count
- en_clockt/s_clockt  out  1/1  game clock enable / 0 clear
- plot  out  1; s_color out 2  0 black, 1 player, 2 ice, 3 end
- level  out  4  current level index (maze memory bank)
- lives_left  out  4  remaining lives
- game_over  out  1  high in GAME_OVER
- state_cur  out  5  current state code

Behaviour:
- reset low (any time, mid-operation included):
  - state = INIT_RESET, level = 0, lives_left = LIVES, freeze_cnt = 0 immediately.
  - Outputs take the INIT_RESET decode.
- Outputs are combinational from state. Defaults: all en_* = 0, selects = 0, plot = 0, en_clockt = 1, s_clockt = 1.
- State codes:
  - 0 INIT, 1 WAIT_TIMER, 2 ERASE, 3 READ_KEY, 4 UPDATE_OBS_MEM, 5 WAIT_OBS_MEM, 6 TEST_OBS, 7 RESTART, 8 FROZEN.
  - 9 LEVEL_UP, 10 GAME_OVER.
  - 15 INC_XPOS, 16 DEC_XPOS, 17 INC_YPOS, 18 DEC_YPOS, 20 DRAW, 21 WIN, 22 INIT_RESET, 23 INIT_SET_END_PIXEL.
- INIT_RESET: plot, colour 0; load end position (s_xpos = s_ypos = 3) -> INIT_SET_END_PIXEL.
- INIT_SET_END_PIXEL: plot colour 3 -> INIT.
- INIT: clear timer, key, obs; load start position; s_clockt = 0 only when level == 0 and lives_left == LIVES -> WAIT_TIMER.
- WAIT_TIMER:
  - en_timer = ~pause, s_timer = 1.
  - timer_done & ~pause -> ERASE; otherwise stay.
- ERASE (plot colour 0, clear timer) -> READ_KEY -> UPDATE_OBS_MEM (en_obs, s_obs = move) -> WAIT_OBS_MEM -> TEST_OBS.
- TEST_OBS, priority wall > lava > ice > move:
  - wall -> DRAW.
  - lava: lives_left decrements on the exit edge. If lives_left == 1 -> GAME_OVER, else RESTART.
  - ice: freeze_cnt = 0 -> FROZEN.
  - move 1/2/3/4 -> DEC_XPOS/INC_XPOS/DEC_YPOS/INC_YPOS; move 0 or 5..7 -> DRAW.
- RESTART: load start position -> DRAW.
- FROZEN:
  - plot colour 2, en_timer = 1, s_timer = 1.
  - freeze_cnt increments on each timer_done.
  - timer_done with freeze_cnt == FREEZE_TICKS-1 -> WAIT_TIMER, freeze_cnt cleared.
- INC/DEC states: one-cycle position step -> DRAW.
- DRAW: plot colour 1.
  - win & level == LEVELS-1 -> WIN.
  - win otherwise -> LEVEL_UP.
  - no win -> WAIT_TIMER.
- LEVEL_UP: level increments; lives retained -> INIT_RESET.
- WIN: en_clockt = 0, plot colour 0; terminal until reset.
- GAME_OVER: en_clockt = 0, game_over = 1, lives_left = 0; terminal until reset.
- lives_left never underflows.
- Unreachable state codes -> INIT_RESET.

Test Plan:
- Reset low mid-FROZEN, then release -> state_cur 22 next cycle, then 23 then 0; level 0, lives_left 3; s_xpos = s_ypos = 3 in first cycle.
- move = 2, all obstacle flags 0, timer_done pulse -> sequence 2,3,4,5,6,15,20,1; en_xpos with s_xpos = 1 for exactly one cycle.
- obs_ice = 1 with FREEZE_TICKS = 8 -> state 8 holds through 7 timer_done pulses and exits to 1 on the 8th; plot with colour 2 throughout.
- Three consecutive lava hits -> lives_left 2, 1, 0; third hit enters 10 with game_over = 1 and en_clockt = 0.
- win during DRAW at level 0 -> 9, then 22; level = 1, clock not cleared in INIT. With LEVELS = 4, win at level 3 -> 21 and stays there.
- pause = 1 during WAIT_TIMER with timer_done pulsing -> state stays 1, en_timer = 0; release pause -> next timer_done goes to ERASE.
